pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter NUM_STAGES, default 3, number of tracked post-ID stages (0=EXE, 1=MEM, 2=WB), legal 2..6.
REQ-002 SHALL have parameter LOAD_STAGE, default 2, first stage index whose load result is forwardable, legal 1..NUM_STAGES-1.
REQ-003 SHALL have parameter REG_AW, default 4, register-address width.
REQ-004 SHALL have localparam SEL_W = clog2(NUM_STAGES), minimum 1.
REQ-005 SHALL have one clock; reset is asynchronous and active-low.
REQ-006 clk  in  1  rising-edge clock.
REQ-007 rst  in  1  asynchronous active-low reset.
REQ-008 id_valid  in  1  ID holds a real instruction.
REQ-009 id_src1, id_src2  in  REG_AW  ID source registers.
REQ-010 id_use_src1, id_two_src  in  1  src1 read / src2 read qualifiers.
REQ-011 id_dest  in  REG_AW  ID destination.
REQ-012 id_wb_en, id_mem_r_en  in  1  ID writes back / ID is a load.
REQ-013 branch_taken  in  1  EXE branch resolved taken.
REQ-014 stall  out  1  freeze PC and IF/ID this cycle.
REQ-015 sel_src1, sel_src2  out  SEL_W  EXE operand source: 0 = register value, k = stage k result.
REQ-016 exe_valid  out  1  stage 0 holds a real instruction.
REQ-017 stall_cnt  out  16  saturating count of stall cycles.

Function
REQ-018 SHALL hold per stage: valid, dest, wb_en, mem_r_en, src1, src2, src1_used, src2_used.
REQ-019 On each clock edge, stage k SHALL load stage k-1 for k>=1.
REQ-020 On each clock edge, stage 0 SHALL load a bubble (valid=0) when stall or branch_taken, else the ID fields with valid=id_valid.
REQ-021 branch_taken together with stall SHALL insert one bubble only; flush takes priority; stall_cnt still increments.
REQ-022 A match SHALL exist on stage k when stage valid, stage wb_en, an ID source used (src1 when id_use_src1, src2 when id_two_src), and that source equals stage dest; a match requires id_valid.
REQ-023 With forwarding, stall SHALL be 1 iff a match exists on stage k with mem_r_en=1 and k+1 < LOAD_STAGE.
REQ-024 sel_src1 SHALL be the lowest k in 1..NUM_STAGES-1 whose stage is valid, wb_en=1 and dest = stage-0 src1 with src1_used=1; otherwise 0; sel_src2 likewise with src2.
REQ-025 sel outputs SHALL be 0 when stage 0 is a bubble.
REQ-026 stall, sel_src1 and sel_src2 SHALL be combinational from current state and ID inputs, with zero latency.
REQ-027 stall_cnt SHALL increment on each edge where stall=1 and hold at 16'hFFFF.
REQ-028 exe_valid SHALL equal stage-0 valid.

Reset
REQ-029 rst=0 SHALL asynchronously clear all stage valid bits and stall_cnt; stall, sel_src1 and sel_src2 are then 0.
REQ-030 Reset asserted mid-stall SHALL drop stall within the same cycle; the first edge after release loads ID normally.

Configuration
REQ-031 With macro PIPE_FORWARD_EN defined, SHALL behave as REQ-023/REQ-024.
REQ-032 Without PIPE_FORWARD_EN, sel outputs SHALL be tied to 0, and stall SHALL be 1 iff a match exists on any stage k in 0..NUM_STAGES-2, regardless of mem_r_en.

Verification
REQ-033 Defaults, forwarding: ADD r3 in EXE, next ID reads r3 -> stall=0; one edge later sel_src1=1.
REQ-034 Defaults, forwarding: LDR r5 in EXE, ID reads r5 as src2 with id_two_src=1 -> stall=1 for exactly one cycle, stall_cnt=1; then sel_src2=2.
REQ-035 r2 written by both MEM and WB stages, EXE reads r2 -> sel_src1=1, nearest stage wins.
REQ-036 No PIPE_FORWARD_EN: ADD r4 in EXE, ID reads r4 -> stall=1 for two cycles; sel outputs 0 throughout.
REQ-037 branch_taken=1 while stall=1 -> stage 0 is a bubble next cycle, exe_valid=0, stall_cnt incremented.
REQ-038 Force 70000 stall cycles -> stall_cnt=16'hFFFF; then rst=0 mid-cycle -> stall_cnt=0 and stall=0 immediately.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//
// Purpose:
//   Tracks the instructions that have left ID in a short in-order pipeline
//   (stage 0 = EXE, 1 = MEM, 2 = WB, ...). It decides whether the instruction
//   in ID must be held back (stall). When forwarding is built in, it also
//   tells EXE where each operand should come from (sel_src1 / sel_src2).
//
// Configuration macro:
//   PIPE_FORWARD_EN - when defined, results are forwarded from later stages.
//                     Only loads that are still too young cause a stall.
//                     When undefined, the sel outputs are tied to 0. ID then
//                     stalls on any producer that has not yet reached the
//                     last tracked stage.
//
// Parameters:
//   NUM_STAGES - tracked post-ID stages (2..6)
//   LOAD_STAGE - first stage whose load result can be forwarded
//   REG_AW     - register address width
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-low reset
//   id_valid     ID holds a real instruction
//   id_src1/2    ID source registers
//   id_use_src1  ID reads src1
//   id_two_src   ID reads src2
//   id_dest      ID destination register
//   id_wb_en     ID writes back
//   id_mem_r_en  ID is a load
//   branch_taken EXE resolved a taken branch (flush)
//   stall        freeze PC and IF/ID this cycle
//   sel_src1/2   EXE operand source: 0 = register file, k = stage k result
//   exe_valid    stage 0 holds a real instruction
//   stall_cnt    saturating count of stall cycles
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int NUM_STAGES = 3,
    parameter int LOAD_STAGE = 2,
    parameter int REG_AW     = 4,
    localparam int SEL_W     = (NUM_STAGES > 2) ? $clog2(NUM_STAGES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_use_src1,
    input  logic              id_two_src,
    input  logic [REG_AW-1:0] id_dest,
    input  logic              id_wb_en,
    input  logic              id_mem_r_en,
    input  logic              branch_taken,
    output logic              stall,
    output logic [SEL_W-1:0]  sel_src1,
    output logic [SEL_W-1:0]  sel_src2,
    output logic              exe_valid,
    output logic [15:0]       stall_cnt
);

    logic [NUM_STAGES-1:0]             r_valid;
    logic [NUM_STAGES-1:0]             r_wbEn;
    logic [NUM_STAGES-1:0]             r_memREn;
    logic [NUM_STAGES-1:0]             r_use1;
    logic [NUM_STAGES-1:0]             r_use2;
    logic [NUM_STAGES-1:0][REG_AW-1:0] r_dest;
    logic [NUM_STAGES-1:0][REG_AW-1:0] r_src1;
    logic [NUM_STAGES-1:0][REG_AW-1:0] r_src2;
    logic [15:0]                       r_stallCnt;

    logic [NUM_STAGES-1:0] w_match;
    logic                  w_stall;
    logic [SEL_W-1:0]      w_sel1;
    logic [SEL_W-1:0]      w_sel2;
    logic                  w_unused;

    // A stage conflicts with ID when it will write a register that ID reads.
    // The stage must be live and actually write back.
    always_comb begin
        w_match = '0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            w_match[k] = id_valid && r_valid[k] && r_wbEn[k] &&
                         ((id_use_src1 && (id_src1 == r_dest[k])) ||
                          (id_two_src  && (id_src2 == r_dest[k])));
        end
    end

`ifdef PIPE_FORWARD_EN
    // Only a load that has not yet reached LOAD_STAGE is a problem. Its data
    // would not exist by the time the ID instruction reaches EXE.
    always_comb begin
        w_stall = 1'b0;
        for (int k = 0; k < NUM_STAGES; k++) begin
            if (((k + 1) < LOAD_STAGE) && w_match[k] && r_memREn[k]) begin
                w_stall = 1'b1;
            end
        end
    end

    // Scan from the oldest stage down to stage 1 so the youngest (nearest)
    // producer is written last and wins. An EXE bubble never forwards.
    always_comb begin
        w_sel1 = '0;
        w_sel2 = '0;
        for (int k = NUM_STAGES - 1; k >= 1; k--) begin
            if (r_valid[0] && r_use1[0] && r_valid[k] && r_wbEn[k] &&
                (r_dest[k] == r_src1[0])) begin
                w_sel1 = SEL_W'(k);
            end
            if (r_valid[0] && r_use2[0] && r_valid[k] && r_wbEn[k] &&
                (r_dest[k] == r_src2[0])) begin
                w_sel2 = SEL_W'(k);
            end
        end
    end
`else
    // Without forwarding, every producer must reach the last tracked stage
    // before its result can be read from the register file.
    always_comb begin
        w_stall = |w_match[NUM_STAGES-2:0];
    end

    assign w_sel1 = '0;
    assign w_sel2 = '0;
`endif

    // Stage shift register. On a stall or flush, EXE receives a bubble.
    // The ID fields are still copied into stage 0, but only the valid bit
    // is meaningful for a bubble. Flush and stall together give one bubble.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid    <= '0;
            r_wbEn     <= '0;
            r_memREn   <= '0;
            r_use1     <= '0;
            r_use2     <= '0;
            r_dest     <= '0;
            r_src1     <= '0;
            r_src2     <= '0;
            r_stallCnt <= '0;
        end else begin
            for (int k = 1; k < NUM_STAGES; k++) begin
                r_valid[k]  <= r_valid[k-1];
                r_wbEn[k]   <= r_wbEn[k-1];
                r_memREn[k] <= r_memREn[k-1];
                r_use1[k]   <= r_use1[k-1];
                r_use2[k]   <= r_use2[k-1];
                r_dest[k]   <= r_dest[k-1];
                r_src1[k]   <= r_src1[k-1];
                r_src2[k]   <= r_src2[k-1];
            end
            r_valid[0]  <= id_valid && !w_stall && !branch_taken;
            r_wbEn[0]   <= id_wb_en;
            r_memREn[0] <= id_mem_r_en;
            r_use1[0]   <= id_use_src1;
            r_use2[0]   <= id_two_src;
            r_dest[0]   <= id_dest;
            r_src1[0]   <= id_src1;
            r_src2[0]   <= id_src2;
            if (w_stall && (r_stallCnt != 16'hFFFF)) begin
                r_stallCnt <= r_stallCnt + 16'd1;
            end
        end
    end

    // Some stage fields are only meaningful in one build flavour.
    // They are collected here so that they do not dangle.
    assign w_unused = ^{w_match, r_valid, r_wbEn, r_memREn, r_use1, r_use2,
                        r_dest, r_src1, r_src2, LOAD_STAGE[0]};

    assign stall     = w_stall;
    assign sel_src1  = w_sel1;
    assign sel_src2  = w_sel2;
    assign exe_valid = r_valid[0];
    assign stall_cnt = r_stallCnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
module tb_pipe_hazard_ctrl;

    localparam int NS     = 3;
    localparam int LS     = 2;
    localparam int SAT_NS = 6;
    localparam int SAT_LS = 5;
`ifdef PIPE_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif
    // In the saturation setup, one hazard repeats every SAT_P edges.
    // One of those edges lets an instruction in; all the others stall.
    localparam int SAT_P   = FWD ? SAT_LS : SAT_NS;
    localparam int SAT_MID = FWD ? 81900 : 78600;
    localparam int SAT_END = FWD ? 82601 : 79300;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_use_src1;
    logic        id_two_src;
    logic [3:0]  id_dest;
    logic        id_wb_en;
    logic        id_mem_r_en;
    logic        branch_taken;
    logic        stall;
    logic [1:0]  sel_src1;
    logic [1:0]  sel_src2;
    logic        exe_valid;
    logic [15:0] stall_cnt;

    logic        sRst;
    logic        sIdValid;
    logic [3:0]  sSrc1;
    logic [3:0]  sSrc2;
    logic        sUse1;
    logic        sTwo;
    logic [3:0]  sDest;
    logic        sWb;
    logic        sMr;
    logic        sBranch;
    logic        sStall;
    logic [2:0]  sSel1;
    logic [2:0]  sSel2;
    logic        sExe;
    logic [15:0] sCnt;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        bit         v;
        logic [3:0] dest;
        bit         wb;
        bit         mr;
        logic [3:0] s1;
        logic [3:0] s2;
        bit         u1;
        bit         u2;
    } instr_t;

    // pipeQ[0] is EXE, and older instructions sit further back in the queue.
    instr_t pipeQ[$];
    int     modelCnt;

    pipe_hazard_ctrl dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
        .id_use_src1(id_use_src1), .id_two_src(id_two_src), .id_dest(id_dest),
        .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en), .branch_taken(branch_taken),
        .stall(stall), .sel_src1(sel_src1), .sel_src2(sel_src2),
        .exe_valid(exe_valid), .stall_cnt(stall_cnt)
    );

    pipe_hazard_ctrl #(.NUM_STAGES(SAT_NS), .LOAD_STAGE(SAT_LS), .REG_AW(4)) u_sat (
        .clk(clk), .rst(sRst), .id_valid(sIdValid), .id_src1(sSrc1), .id_src2(sSrc2),
        .id_use_src1(sUse1), .id_two_src(sTwo), .id_dest(sDest),
        .id_wb_en(sWb), .id_mem_r_en(sMr), .branch_taken(sBranch),
        .stall(sStall), .sel_src1(sSel1), .sel_src2(sSel2),
        .exe_valid(sExe), .stall_cnt(sCnt)
    );

    always #5 clk = ~clk;

    function automatic instr_t bubble();
        instr_t b;
        b = '{default: '0};
        return b;
    endfunction

    function automatic instr_t idInstr();
        instr_t n;
        n.v = id_valid; n.dest = id_dest; n.wb = id_wb_en; n.mr = id_mem_r_en;
        n.s1 = id_src1; n.s2 = id_src2; n.u1 = id_use_src1; n.u2 = id_two_src;
        return n;
    endfunction

    // A result can be read without waiting when forwarding is on and the
    // producer is not a load that is still too young. Without forwarding,
    // the producer must have reached the last tracked stage.
    function automatic bit modelStall();
        bit s;
        bit hit;
        s = 1'b0;
        for (int k = 0; k < NS; k++) begin
            hit = id_valid && pipeQ[k].v && pipeQ[k].wb &&
                  ((id_use_src1 && id_src1 == pipeQ[k].dest) ||
                   (id_two_src && id_src2 == pipeQ[k].dest));
            if (FWD) begin
                if (hit && pipeQ[k].mr && (k + 1) < LS) s = 1'b1;
            end else begin
                if (hit && k < NS - 1) s = 1'b1;
            end
        end
        return s;
    endfunction

    function automatic logic [1:0] modelSel(input bit second);
        logic [3:0] want;
        if (!FWD || !pipeQ[0].v) return 2'd0;
        if (second ? !pipeQ[0].u2 : !pipeQ[0].u1) return 2'd0;
        want = second ? pipeQ[0].s2 : pipeQ[0].s1;
        for (int k = 1; k < NS; k++) begin
            if (pipeQ[k].v && pipeQ[k].wb && pipeQ[k].dest == want) return 2'(k);
        end
        return 2'd0;
    endfunction

    function automatic int satExpect(input int c);
        int e;
        e = c - (c + SAT_P - 1) / SAT_P;
        return (e > 65535) ? 65535 : e;
    endfunction

    task automatic modelReset();
        pipeQ.delete();
        for (int k = 0; k < NS; k++) pipeQ.push_back(bubble());
        modelCnt = 0;
    endtask

    task automatic clockEdge();
        bit     st;
        instr_t n;
        st = modelStall();
        n  = (st || branch_taken) ? bubble() : idInstr();
        @(posedge clk);
        void'(pipeQ.pop_back());
        pipeQ.push_front(n);
        if (st && modelCnt < 65535) modelCnt++;
        #1;
    endtask

    task automatic idle();
        id_valid = 0; id_src1 = 0; id_src2 = 0; id_use_src1 = 0; id_two_src = 0;
        id_dest = 0; id_wb_en = 0; id_mem_r_en = 0; branch_taken = 0;
    endtask

    task automatic setId(input logic [3:0] d, input logic [3:0] s1, input logic [3:0] s2,
                         input bit u1, input bit two, input bit wb, input bit mr);
        id_valid = 1; id_dest = d; id_src1 = s1; id_src2 = s2;
        id_use_src1 = u1; id_two_src = two; id_wb_en = wb; id_mem_r_en = mr;
    endtask

    task automatic resetDut();
        idle();
        rst = 0;
        #2;
        rst = 1;
        modelReset();
    endtask

    task automatic test_reset();
        #1;
        testsRun++;
        if (exe_valid !== 1'b0 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_initial: got exe=%0b stall=%0b cnt=%0d expected 0/0/0", exe_valid, stall, stall_cnt);
        end
        rst = 1;
        modelReset();
        setId(4'd5, 4'd0, 4'd0, 0, 0, 1, 1);
        clockEdge();
        setId(4'd7, 4'd5, 4'd0, 1, 0, 1, 0);
        #1;
        testsRun++;
        if (stall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL reset_prestall: got %0b expected 1", stall);
        end
        clockEdge();
        #1 rst = 0;
        #1;
        testsRun++;
        if (stall !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_stall: got %0b expected 0", stall);
        end
        testsRun++;
        if (sel_src1 !== 2'd0 || sel_src2 !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_sel: got %0d/%0d expected 0/0", sel_src1, sel_src2);
        end
        testsRun++;
        if (exe_valid !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL reset_exe: got %0b expected 0", exe_valid);
        end
        testsRun++;
        if (stall_cnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_cnt: got %0d expected 0", stall_cnt);
        end
        rst = 1;
        modelReset();
        clockEdge();
        testsRun++;
        if (exe_valid !== 1'b1 || stall !== 1'b0 || stall_cnt !== 16'd0) begin
            testsFailed++;
            $display("[TB] FAIL reset_release: got exe=%0b stall=%0b cnt=%0d expected 1/0/0", exe_valid, stall, stall_cnt);
        end
    endtask

    task automatic test_alu_forward();
        int stalls;
        resetDut();
        setId(4'd3, 4'd1, 4'd2, 1, 1, 1, 0);
        clockEdge();
        setId(4'd6, 4'd3, 4'd0, 1, 0, 1, 0);
        #1;
        stalls = 0;
        for (int i = 0; i < 8 && stall; i++) begin
            stalls++;
            clockEdge();
        end
        testsRun++;
        if (stalls != (FWD ? 0 : 2)) begin
            testsFailed++;
            $display("[TB] FAIL alu_stall_cycles: got %0d expected %0d", stalls, FWD ? 0 : 2);
        end
        clockEdge();
        idle();
        #1;
        testsRun++;
        if (sel_src1 !== (FWD ? 2'd1 : 2'd0) || sel_src2 !== 2'd0) begin
            testsFailed++;
            $display("[TB] FAIL alu_sel: got %0d/%0d expected %0d/0", sel_src1, sel_src2, FWD ? 1 : 0);
        end
        testsRun++;
        if (exe_valid !== 1'b1 || stall_cnt !== 16'(FWD ? 0 : 2)) begin
            testsFailed++;
            $display("[TB] FAIL alu_exe_cnt: got %0b/%0d expected 1/%0d", exe_valid, stall_cnt, FWD ? 0 : 2);
        end
    endtask

    task automatic test_load_use();
        int stalls;
        resetDut();
        setId(4'd5, 4'd0, 4'd0, 0, 0, 1, 1);
        clockEdge();
        setId(4'd7, 4'd0, 4'd5, 0, 1, 1, 0);
        #1;
        stalls = 0;
        for (int i = 0; i < 8 && stall; i++) begin
            stalls++;
            clockEdge();
            testsRun++;
            if (sel_src2 !== 2'd0 || exe_valid !== 1'b0) begin
                testsFailed++;
                $display("[TB] FAIL load_bubble_sel: got sel2=%0d exe=%0b expected 0/0", sel_src2, exe_valid);
            end
        end
        testsRun++;
        if (stalls != (FWD ? 1 : 2) || stall_cnt !== 16'(FWD ? 1 : 2)) begin
            testsFailed++;
            $display("[TB] FAIL load_stall: got cycles=%0d cnt=%0d expected %0d", stalls, stall_cnt, FWD ? 1 : 2);
        end
        clockEdge();
        idle();
        #1;
        testsRun++;
        if (sel_src2 !== (FWD ? 2'd2 : 2'd0) || sel_src1 !== 2'd0 || exe_valid !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL load_sel: got sel1=%0d sel2=%0d exe=%0b expected 0/%0d/1", sel_src1, sel_src2, exe_valid, FWD ? 2 : 0);
        end
    endtask

    task automatic test_nearest();
        int stalls;
        resetDut();
        setId(4'd2, 4'd0, 4'd0, 0, 0, 1, 0);
        clockEdge();
        clockEdge();
        setId(4'd9, 4'd2, 4'd0, 1, 0, 1, 0);
        #1;
        stalls = 0;
        for (int i = 0; i < 8 && stall; i++) begin
            stalls++;
            clockEdge();
        end
        testsRun++;
        if (stalls != (FWD ? 0 : 2)) begin
            testsFailed++;
            $display("[TB] FAIL nearest_stall: got %0d expected %0d", stalls, FWD ? 0 : 2);
        end
        clockEdge();
        idle();
        #1;
        testsRun++;
        if (sel_src1 !== (FWD ? 2'd1 : 2'd0)) begin
            testsFailed++;
            $display("[TB] FAIL nearest_sel: got %0d expected %0d", sel_src1, FWD ? 1 : 0);
        end
    endtask

    task automatic test_branch_stall();
        resetDut();
        setId(4'd5, 4'd0, 4'd0, 0, 0, 1, 1);
        clockEdge();
        setId(4'd8, 4'd5, 4'd0, 1, 0, 1, 0);
        #1;
        testsRun++;
        if (stall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL branch_prestall: got %0b expected 1", stall);
        end
        branch_taken = 1;
        clockEdge();
        branch_taken = 0;
        testsRun++;
        if (exe_valid !== 1'b0 || stall_cnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL branch_stall: got exe=%0b cnt=%0d expected 0/1", exe_valid, stall_cnt);
        end
        testsRun++;
        if (stall !== (FWD ? 1'b0 : 1'b1)) begin
            testsFailed++;
            $display("[TB] FAIL branch_after: got %0b expected %0b", stall, FWD ? 1'b0 : 1'b1);
        end
        setId(4'd4, 4'd0, 4'd0, 0, 0, 1, 0);
        branch_taken = 1;
        clockEdge();
        idle();
        #1;
        testsRun++;
        if (exe_valid !== 1'b0 || stall_cnt !== 16'd1) begin
            testsFailed++;
            $display("[TB] FAIL branch_flush: got exe=%0b cnt=%0d expected 0/1", exe_valid, stall_cnt);
        end
    endtask

    task automatic test_random();
        logic [1:0] e1;
        logic [1:0] e2;
        bit         es;
        resetDut();
        for (int i = 0; i < 400; i++) begin
            id_valid     = ($urandom_range(0, 9) < 8);
            id_src1      = 4'($urandom_range(0, 3));
            id_src2      = 4'($urandom_range(0, 3));
            id_use_src1  = 1'($urandom_range(0, 1));
            id_two_src   = 1'($urandom_range(0, 1));
            id_dest      = 4'($urandom_range(0, 3));
            id_wb_en     = ($urandom_range(0, 3) != 0);
            id_mem_r_en  = 1'($urandom_range(0, 1));
            branch_taken = ($urandom_range(0, 9) == 0);
            #1;
            es = modelStall();
            e1 = modelSel(1'b0);
            e2 = modelSel(1'b1);
            testsRun++;
            if (stall !== es) begin
                testsFailed++;
                $display("[TB] FAIL rand_stall@%0d: got %0b expected %0b", i, stall, es);
            end
            testsRun++;
            if (sel_src1 !== e1 || sel_src2 !== e2) begin
                testsFailed++;
                $display("[TB] FAIL rand_sel@%0d: got %0d/%0d expected %0d/%0d", i, sel_src1, sel_src2, e1, e2);
            end
            testsRun++;
            if (exe_valid !== pipeQ[0].v || stall_cnt !== 16'(modelCnt)) begin
                testsFailed++;
                $display("[TB] FAIL rand_state@%0d: got exe=%0b cnt=%0d expected %0b/%0d", i, exe_valid, stall_cnt, pipeQ[0].v, modelCnt);
            end
            clockEdge();
        end
        idle();
    endtask

    task automatic test_saturation();
        sIdValid = 1; sSrc1 = 4'd1; sSrc2 = 4'd0; sUse1 = 1; sTwo = 0;
        sDest = 4'd1; sWb = 1; sMr = 1; sBranch = 0;
        #1 sRst = 1;
        for (int c = 1; c <= SAT_END; c++) begin
            @(posedge clk);
            if (c == 10 || c == SAT_MID || c == SAT_END) begin
                #1;
                testsRun++;
                if (sCnt !== 16'(satExpect(c))) begin
                    testsFailed++;
                    $display("[TB] FAIL sat_cnt@%0d: got %0d expected %0d", c, sCnt, satExpect(c));
                end
            end
        end
        testsRun++;
        if (sStall !== 1'b1) begin
            testsFailed++;
            $display("[TB] FAIL sat_prestall: got %0b expected 1", sStall);
        end
        #2 sRst = 0;
        #1;
        testsRun++;
        if (sStall !== 1'b0 || sCnt !== 16'd0 || sExe !== 1'b0) begin
            testsFailed++;
            $display("[TB] FAIL sat_reset: got stall=%0b cnt=%0d exe=%0b expected 0/0/0", sStall, sCnt, sExe);
        end
    endtask

    initial begin
        rst = 0;
        sRst = 0;
        idle();
        sIdValid = 0; sSrc1 = 0; sSrc2 = 0; sUse1 = 0; sTwo = 0;
        sDest = 0; sWb = 0; sMr = 0; sBranch = 0;
        modelReset();
        test_reset();
        test_alu_forward();
        test_load_use();
        test_nearest();
        test_branch_stall();
        test_random();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
